// File: rtl/scroll_display_ctrl.sv
// Multiplexed scrolling-text controller for common-anode 7-segment displays.
// Holds a message RAM and scrolls a NUM_DIGITS-wide window across it.
module scroll_display_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int MSG_DEPTH    = 16,
    parameter int CHAR_W       = 4,
    parameter int REFRESH_DIV  = 5000,
    parameter int BLANK_CYCLES = 50,
    parameter int SCROLL_DIV   = 5000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         scroll_en,
    input  logic                         dir,
    input  logic                         step,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [CHAR_W-1:0]            char_out,
    output logic [$clog2(MSG_DEPTH)-1:0] offset,
    output logic                         wrap
);
    localparam int AW  = $clog2(MSG_DEPTH);
    localparam int LW  = AW + 1;
    localparam int DW  = $clog2(NUM_DIGITS);
    localparam int RW  = $clog2(REFRESH_DIV + 1);
    localparam int SCW = $clog2(SCROLL_DIV + 1);
    localparam int SW  = LW + 3;
    localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0]  REF_BLANK = RW'(BLANK_CYCLES);
    localparam logic [SCW-1:0] SCR_LAST  = SCW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0]  DIG_LAST  = DW'(NUM_DIGITS - 1);

    logic [CHAR_W-1:0]     r_mem [MSG_DEPTH];
    logic [RW-1:0]         r_ref_cnt;
    logic [DW-1:0]         r_dig_sel;
    logic [SCW-1:0]        r_scr_cnt;
    logic [AW-1:0]         r_offset;
    logic                  r_wrap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [CHAR_W-1:0]     r_char;

    logic                  w_len_zero;
    logic                  w_tick;
    logic                  w_move;
    logic [DW-1:0]         w_pos;
    logic [SW-1:0]         w_sum;
    logic [AW-1:0]         w_idx;
    logic [AW-1:0]         w_offset_nxt;
    logic                  w_wrap_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [CHAR_W-1:0]     w_char_nxt;
    logic [NUM_DIGITS-1:0] w_one_hot;

    assign w_len_zero = (msg_len == {LW{1'b0}});
    assign w_tick     = scroll_en && (r_scr_cnt == SCR_LAST);
    assign w_move     = w_tick || step;
    assign w_pos      = DIG_LAST - r_dig_sel;
    assign w_sum      = SW'(r_offset) + SW'(w_pos);
    assign w_one_hot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_dig_sel;

    // Window character index; true modulo so short messages repeat across digits
    always_comb begin
        w_idx = {AW{1'b0}};
        if (w_len_zero) begin
            w_idx = {AW{1'b0}};
        end else begin
            w_idx = AW'(w_sum % SW'(msg_len));
        end
    end

    // Next offset and wrap flag; an out-of-range offset is pulled back silently
    always_comb begin
        w_offset_nxt = r_offset;
        w_wrap_nxt   = 1'b0;
        if (w_len_zero || ({1'b0, r_offset} >= msg_len)) begin
            w_offset_nxt = {AW{1'b0}};
        end else if (w_move) begin
            if (dir == 1'b0) begin
                if (({1'b0, r_offset} + {{AW{1'b0}}, 1'b1}) == msg_len) begin
                    w_offset_nxt = {AW{1'b0}};
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_offset_nxt = r_offset + {{(AW-1){1'b0}}, 1'b1};
                end
            end else begin
                if (r_offset == {AW{1'b0}}) begin
                    w_offset_nxt = AW'(msg_len - {{AW{1'b0}}, 1'b1});
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_offset_nxt = r_offset - {{(AW-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            w_offset_nxt = r_offset;
        end
    end

    // Anode and character for the next output register update
    always_comb begin
        w_an_nxt   = {NUM_DIGITS{1'b1}};
        w_char_nxt = {CHAR_W{1'b0}};
        if (w_len_zero) begin
            w_an_nxt   = {NUM_DIGITS{1'b1}};
            w_char_nxt = {CHAR_W{1'b0}};
        end else begin
            w_char_nxt = r_mem[w_idx];
            if (r_ref_cnt < REF_BLANK) begin
                w_an_nxt = {NUM_DIGITS{1'b1}};
            end else begin
                w_an_nxt = ~w_one_hot;
            end
        end
    end

    // Message RAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_mem[i] <= {CHAR_W{1'b0}};
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Refresh slot counter and digit selector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ref_cnt <= {RW{1'b0}};
            r_dig_sel <= DIG_LAST;
        end else if (r_ref_cnt == REF_LAST) begin
            r_ref_cnt <= {RW{1'b0}};
            r_dig_sel <= (r_dig_sel == {DW{1'b0}}) ? DIG_LAST : (r_dig_sel - {{(DW-1){1'b0}}, 1'b1});
        end else begin
            r_ref_cnt <= r_ref_cnt + {{(RW-1){1'b0}}, 1'b1};
        end
    end

    // Scroll prescaler, frozen while automatic scrolling is off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scr_cnt <= {SCW{1'b0}};
        end else if (scroll_en) begin
            r_scr_cnt <= (r_scr_cnt == SCR_LAST) ? {SCW{1'b0}} : (r_scr_cnt + {{(SCW-1){1'b0}}, 1'b1});
        end else begin
            r_scr_cnt <= r_scr_cnt;
        end
    end

    // Registered window offset and display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_offset <= {AW{1'b0}};
            r_wrap   <= 1'b0;
            r_an     <= {NUM_DIGITS{1'b1}};
            r_char   <= {CHAR_W{1'b0}};
        end else begin
            r_offset <= w_offset_nxt;
            r_wrap   <= w_wrap_nxt;
            r_an     <= w_an_nxt;
            r_char   <= w_char_nxt;
        end
    end

    assign an       = r_an;
    assign char_out = r_char;
    assign offset   = r_offset;
    assign wrap     = r_wrap;
endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed bench for scroll_display_ctrl: table of per-cycle vectors plus
// hand-written sequences for scrolling, wrap, length changes and reset.
module tb_scroll_display_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic [4:0] msg_len = 5'd0;
    logic       scroll_en = 1'b0;
    logic       dir = 1'b0;
    logic       step = 1'b0;
    logic [3:0] an;
    logic [3:0] char_out;
    logic [3:0] offset;
    logic       wrap;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [3:0] wd;
        logic [4:0] len;
        logic [3:0] e_an;
        logic [3:0] e_ch;
        logic       ck_ch;
    } vec_t;

    vec_t tbl[32];

    scroll_display_ctrl #(
        .NUM_DIGITS(4), .MSG_DEPTH(16), .CHAR_W(4),
        .REFRESH_DIV(4), .BLANK_CYCLES(1), .SCROLL_DIV(8)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .msg_len(msg_len), .scroll_en(scroll_en),
        .dir(dir), .step(step), .an(an), .char_out(char_out),
        .offset(offset), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run one full frame and record the character shown on each digit
    task automatic chk_frame(input string name, input logic [3:0] e3, input logic [3:0] e2,
                             input logic [3:0] e1, input logic [3:0] e0);
        logic [3:0] c3, c2, c1, c0;
        c3 = 4'hx; c2 = 4'hx; c1 = 4'hx; c0 = 4'hx;
        for (int i = 0; i < 17; i++) begin
            cyc();
            if (an == 4'b0111) c3 = char_out;
            if (an == 4'b1011) c2 = char_out;
            if (an == 4'b1101) c1 = char_out;
            if (an == 4'b1110) c0 = char_out;
        end
        chk({name, " dig3"}, 32'(c3), 32'(e3));
        chk({name, " dig2"}, 32'(c2), 32'(e2));
        chk({name, " dig1"}, 32'(c1), 32'(e1));
        chk({name, " dig0"}, 32'(c0), 32'(e0));
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    initial begin
        logic [3:0] an_pat [4];
        bit seen;
        an_pat[0] = 4'b0111; an_pat[1] = 4'b1011; an_pat[2] = 4'b1101; an_pat[3] = 4'b1110;
        // Rows 0..15 load RAM[i]=i with the display disabled; rows 16..31 show one frame
        for (int i = 0; i < 16; i++) begin
            tbl[i].we = 1'b1; tbl[i].wa = 4'(i); tbl[i].wd = 4'(i); tbl[i].len = 5'd0;
            tbl[i].e_an = 4'hF; tbl[i].e_ch = 4'd0; tbl[i].ck_ch = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            tbl[16+i].we = 1'b0; tbl[16+i].wa = 4'd0; tbl[16+i].wd = 4'd0; tbl[16+i].len = 5'd16;
            tbl[16+i].e_an  = ((i % 4) == 0) ? 4'hF : an_pat[i/4];
            tbl[16+i].e_ch  = 4'(i / 4);
            tbl[16+i].ck_ch = ((i % 4) != 0);
        end

        #12;
        chk("reset an", 32'(an), 32'hF);
        chk("reset char", 32'(char_out), 32'h0);
        chk("reset offset", 32'(offset), 32'h0);
        chk("reset wrap", 32'(wrap), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; msg_len = tbl[i].len;
            cyc();
            chk($sformatf("vec%0d an", i), 32'(an), 32'(tbl[i].e_an));
            if (tbl[i].ck_ch) chk($sformatf("vec%0d char", i), 32'(char_out), 32'(tbl[i].e_ch));
            chk($sformatf("vec%0d offset", i), 32'(offset), 32'h0);
            chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'h0);
        end
        wr_en = 1'b0;

        // Automatic scroll left through a full revolution
        scroll_en = 1'b1; dir = 1'b0;
        for (int e = 1; e <= 128; e++) begin
            cyc();
            chk($sformatf("scroll e%0d offset", e), 32'(offset), 32'((e / 8) % 16));
            chk($sformatf("scroll e%0d wrap", e), 32'(wrap), (e == 128) ? 32'h1 : 32'h0);
        end
        scroll_en = 1'b0;
        cyc();
        chk("wrap one cycle", 32'(wrap), 32'h0);
        chk_frame("after wrap", 4'd0, 4'd1, 4'd2, 4'd3);

        // Step backwards across zero
        dir = 1'b1;
        do_step();
        chk("back offset", 32'(offset), 32'd15);
        chk("back wrap", 32'(wrap), 32'h1);
        cyc();
        chk("back wrap clear", 32'(wrap), 32'h0);
        chk_frame("back frame", 4'd15, 4'd0, 4'd1, 4'd2);
        dir = 1'b0;

        // Short message repeats; shrinking length pulls offset in range
        wr_en = 1'b1;
        wr_addr = 4'd0; wr_data = 4'd5; cyc();
        wr_addr = 4'd1; wr_data = 4'd6; cyc();
        wr_addr = 4'd2; wr_data = 4'd7; cyc();
        wr_en = 1'b0;
        msg_len = 5'd3;
        cyc();
        chk("len3 clamp offset", 32'(offset), 32'h0);
        chk("len3 clamp wrap", 32'(wrap), 32'h0);
        chk_frame("len3", 4'd5, 4'd6, 4'd7, 4'd5);
        do_step();
        chk("len3 step1", 32'(offset), 32'd1);
        do_step();
        chk("len3 step2", 32'(offset), 32'd2);
        chk("len3 step2 wrap", 32'(wrap), 32'h0);
        msg_len = 5'd2;
        cyc();
        chk("len2 clamp offset", 32'(offset), 32'h0);
        chk("len2 clamp wrap", 32'(wrap), 32'h0);
        chk_frame("len2", 4'd5, 4'd6, 4'd5, 4'd6);

        // Manual steps, then a step landing on a scroll tick
        msg_len = 5'd16;
        do_step();
        chk("step a", 32'(offset), 32'd1);
        do_step();
        chk("step b", 32'(offset), 32'd2);
        repeat (3) cyc();
        chk("step hold", 32'(offset), 32'd2);
        scroll_en = 1'b1;
        repeat (7) cyc();
        chk("pre tick", 32'(offset), 32'd2);
        do_step();
        chk("tick+step single move", 32'(offset), 32'd3);
        repeat (7) cyc();
        chk("tick counter restarted", 32'(offset), 32'd3);
        cyc();
        chk("next tick", 32'(offset), 32'd4);
        scroll_en = 1'b0;

        // Empty message blanks everything
        msg_len = 5'd0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("len0 c%0d an", i), 32'(an), 32'hF);
            chk($sformatf("len0 c%0d char", i), 32'(char_out), 32'h0);
            chk($sformatf("len0 c%0d offset", i), 32'(offset), 32'h0);
        end

        // Asynchronous reset while a digit is lit
        msg_len = 5'd16;
        do_step();
        do_step();
        chk("pre reset offset", 32'(offset), 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (an != 4'hF) seen = 1'b1;
        end
        chk("digit lit before reset", 32'(seen), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid reset an", 32'(an), 32'hF);
        chk("mid reset offset", 32'(offset), 32'h0);
        chk("mid reset char", 32'(char_out), 32'h0);
        chk("mid reset wrap", 32'(wrap), 32'h0);
        #20;
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
